// File: rtl/ram_target.sv
// Memory-side responder: little-endian word RAM in the RAM region, with
// programmable wait states, sub-word read-modify-write and a 4-phase handshake.
module ram_target #(
   parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable_n,
   input  logic        is_write,
   input  logic        is_unsigned,
   input  logic [1:0]  op_size,
   input  logic [31:0] addr,
   input  logic [31:0] in,
   output logic [31:0] out,
   output logic        done,
   output logic        op_fault,
   output logic        addr_fault,
   output logic        access_fault_n
);
   localparam int IDXW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  waitCnt_q, waitCnt_d;
   logic        isWrite_q, isWrite_d;
   logic        isUnsigned_q, isUnsigned_d;
   logic [1:0]  opSize_q, opSize_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] out_q, out_d;
   logic        done_q, done_d;
   logic        opFault_q, opFault_d;
   logic        addrFault_q, addrFault_d;
   logic        accessFaultN_q, accessFaultN_d;

   logic [31:0]     mem [DEPTH_WORDS];
   logic [IDXW-1:0] index;
   logic [31:0]     rdWord, mergedWord, loadValue;
   logic [7:0]      selByte;
   logic [15:0]     selHalf;
   logic            opFaultNow, addrFaultNow, inWindow, anyFault, memWe;

   // BASE_ADDR is aligned to the window size, so an upper-bit compare is an
   // exact range check that can never wrap back into the window.
   assign index        = addr_q[IDXW+1:2];
   assign inWindow     = (addr_q[31:IDXW+2] == BASE_ADDR[31:IDXW+2]);
   assign opFaultNow   = (opSize_q == 2'b11);
   assign addrFaultNow = (opSize_q[1] & (|addr_q[1:0])) | (opSize_q[0] & addr_q[0]);
   assign anyFault     = opFaultNow | addrFaultNow | ~inWindow;
   assign rdWord       = mem[index];

   always_comb begin
      mergedWord = rdWord;
      case (opSize_q)
         2'b00: begin
            case (addr_q[1:0])
               2'b00:   mergedWord[7:0]   = wdata_q[7:0];
               2'b01:   mergedWord[15:8]  = wdata_q[7:0];
               2'b10:   mergedWord[23:16] = wdata_q[7:0];
               default: mergedWord[31:24] = wdata_q[7:0];
            endcase
         end
         2'b01: begin
            if (addr_q[1]) mergedWord[31:16] = wdata_q[15:0];
            else           mergedWord[15:0]  = wdata_q[15:0];
         end
         default: mergedWord = wdata_q;
      endcase
   end

   always_comb begin
      case (addr_q[1:0])
         2'b00:   selByte = rdWord[7:0];
         2'b01:   selByte = rdWord[15:8];
         2'b10:   selByte = rdWord[23:16];
         default: selByte = rdWord[31:24];
      endcase
      selHalf = addr_q[1] ? rdWord[31:16] : rdWord[15:0];
      case (opSize_q)
         2'b00:   loadValue = is_sub_ext8(selByte, isUnsigned_q);
         2'b01:   loadValue = isUnsigned_q ? {16'b0, selHalf} : {{16{selHalf[15]}}, selHalf};
         default: loadValue = rdWord;
      endcase
   end

   function automatic logic [31:0] is_sub_ext8(input logic [7:0] b, input logic zeroExt);
      return zeroExt ? {24'b0, b} : {{24{b[7]}}, b};
   endfunction

   always_comb begin
      state_d        = state_q;
      waitCnt_d      = waitCnt_q;
      isWrite_d      = isWrite_q;
      isUnsigned_d   = isUnsigned_q;
      opSize_d       = opSize_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      out_d          = out_q;
      done_d         = done_q;
      opFault_d      = opFault_q;
      addrFault_d    = addrFault_q;
      accessFaultN_d = accessFaultN_q;
      memWe          = 1'b0;
      case (state_q)
         IDLE: begin
            if (!enable_n) begin
               isWrite_d      = is_write;
               isUnsigned_d   = is_unsigned;
               opSize_d       = op_size;
               addr_d         = addr;
               wdata_d        = in;
               done_d         = 1'b0;
               opFault_d      = 1'b0;
               addrFault_d    = 1'b0;
               accessFaultN_d = 1'b1;
               waitCnt_d      = 4'd0;
               state_d        = (WAIT_STATES > 0) ? WAIT : ACCESS;
            end
         end
         WAIT: begin
            if (enable_n) begin
               state_d = IDLE;
            end else if (waitCnt_q == 4'(WAIT_STATES - 1)) begin
               waitCnt_d = 4'd0;
               state_d   = ACCESS;
            end else begin
               waitCnt_d = waitCnt_q + 4'd1;
            end
         end
         ACCESS: begin
            if (enable_n) begin
               state_d = IDLE;
            end else begin
               opFault_d      = opFaultNow;
               addrFault_d    = addrFaultNow;
               accessFaultN_d = inWindow;
               state_d        = RESP;
               if (anyFault || isWrite_q) begin
                  out_d = 32'd0;
               end else begin
                  out_d = loadValue;
               end
               memWe = isWrite_q & ~anyFault;
            end
         end
         RESP: begin
            // done rises one edge after RESP is entered and drops on release
            if (enable_n) begin
               state_d = IDLE;
               done_d  = 1'b0;
            end else begin
               done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         waitCnt_q      <= 4'd0;
         isWrite_q      <= 1'b0;
         isUnsigned_q   <= 1'b0;
         opSize_q       <= 2'b00;
         addr_q         <= 32'd0;
         wdata_q        <= 32'd0;
         out_q          <= 32'd0;
         done_q         <= 1'b0;
         opFault_q      <= 1'b0;
         addrFault_q    <= 1'b0;
         accessFaultN_q <= 1'b1;
      end else begin
         state_q        <= state_d;
         waitCnt_q      <= waitCnt_d;
         isWrite_q      <= isWrite_d;
         isUnsigned_q   <= isUnsigned_d;
         opSize_q       <= opSize_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         out_q          <= out_d;
         done_q         <= done_d;
         opFault_q      <= opFault_d;
         addrFault_q    <= addrFault_d;
         accessFaultN_q <= accessFaultN_d;
      end
   end

   // Array contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (memWe) mem[index] <= mergedWord;
   end

   assign out            = out_q;
   assign done           = done_q;
   assign op_fault       = opFault_q;
   assign addr_fault     = addrFault_q;
   assign access_fault_n = accessFaultN_q;
endmodule

// File: tb/tb_ram_target.sv
// Scoreboard bench for ram_target: a slow instance (one wait state) and a
// fast instance (no wait states) checked against a byte-level memory model.
module tb_ram_target;
   typedef struct {
      string       tag;
      logic [31:0] out;
      logic        opf;
      logic        af;
      logic        afn;
   } expT;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enN1, enN0;
   logic        isWr, isUns;
   logic [1:0]  opSz;
   logic [31:0] addrIn, dataIn;
   logic [31:0] out1, out0;
   logic        done1, done0, opf1, opf0, af1, af0, afn1, afn0;
   logic        sel;
   logic [31:0] obsOut;
   logic        obsDone, obsOpf, obsAf, obsAfn;

   int          total = 0;
   int          bad = 0;
   expT         sb[$];
   logic [7:0]  refByte [longint unsigned];
   logic [31:0] lastOut1;

   assign obsOut  = sel ? out0  : out1;
   assign obsDone = sel ? done0 : done1;
   assign obsOpf  = sel ? opf0  : opf1;
   assign obsAf   = sel ? af0   : af1;
   assign obsAfn  = sel ? afn0  : afn1;

   always #5 clk = ~clk;

   ram_target #(.BASE_ADDR(32'h2000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(1)) dutSlow (
      .clk(clk), .reset_n(reset_n), .enable_n(enN1), .is_write(isWr), .is_unsigned(isUns),
      .op_size(opSz), .addr(addrIn), .in(dataIn), .out(out1), .done(done1),
      .op_fault(opf1), .addr_fault(af1), .access_fault_n(afn1));

   ram_target #(.BASE_ADDR(32'h2000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dutFast (
      .clk(clk), .reset_n(reset_n), .enable_n(enN0), .is_write(isWr), .is_unsigned(isUns),
      .op_size(opSz), .addr(addrIn), .in(dataIn), .out(out0), .done(done0),
      .op_fault(opf0), .addr_fault(af0), .access_fault_n(afn0));

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Byte-addressed reference: faults follow the address window and natural
   // alignment; legal stores write bytes, legal loads gather and extend them.
   task automatic modelRequest(input logic s, input logic wr, input logic uns, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] d, input string tag,
                               output expT e);
      int unsigned     align, nb;
      longint unsigned la, key;
      logic [31:0]     v;
      e.tag = tag;
      e.out = 32'd0;
      e.opf = (sz == 2'b11);
      align = (sz == 2'b11) ? 32'd4 : (32'd1 << sz);
      e.af  = (a % align) != 32'd0;
      la    = {32'd0, a};
      e.afn = (la >= 64'h2000_0000) && (la < 64'h2000_1000);
      if (e.opf || e.af || !e.afn) return;
      nb = 32'd1 << sz;
      v  = 32'd0;
      for (int i = 0; i < int'(nb); i++) begin
         key = {31'd0, s, a} + 64'(i);
         if (wr) refByte[key] = d[8*i +: 8];
         else    v[8*i +: 8]  = refByte[key];
      end
      if (!wr) begin
         if (nb == 1)      e.out = uns ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
         else if (nb == 2) e.out = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
         else              e.out = v;
      end
   endtask

   // Called at a falling edge; leaves on a falling edge after releasing enable_n.
   task automatic applyStimulus(input logic s, input logic wr, input logic uns, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] d, input string tag,
                                input int holdCycles);
      expT e;
      int  edges;
      int  wsExp;
      sel    = s;
      isWr   = wr;
      isUns  = uns;
      opSz   = sz;
      addrIn = a;
      dataIn = d;
      modelRequest(s, wr, uns, sz, a, d, tag, e);
      sb.push_back(e);
      if (s) enN0 = 1'b0;
      else   enN1 = 1'b0;
      edges = 0;
      do begin
         @(negedge clk);
         edges++;
      end while (!obsDone && edges < 40);
      wsExp = s ? 0 : 1;
      checkOutput({tag, ".lat"}, 32'(edges - 1), 32'(wsExp + 2));
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput({e.tag, ".out"}, obsOut, e.out);
         checkOutput({e.tag, ".opf"}, {31'd0, obsOpf}, {31'd0, e.opf});
         checkOutput({e.tag, ".af"},  {31'd0, obsAf},  {31'd0, e.af});
         checkOutput({e.tag, ".afn"}, {31'd0, obsAfn}, {31'd0, e.afn});
         if (!s) lastOut1 = e.out;
      end
      for (int h = 0; h < holdCycles; h++) begin
         @(negedge clk);
         checkOutput({tag, ".holdDone"}, {31'd0, obsDone}, 32'd1);
         checkOutput({tag, ".holdOut"}, obsOut, e.out);
      end
      if (s) enN0 = 1'b1;
      else   enN1 = 1'b1;
      @(negedge clk);
      checkOutput({tag, ".drop"}, {31'd0, obsDone}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset_n = 1'b0;
      enN1 = 1'b1;  enN0 = 1'b1;
      isWr = 1'b0;  isUns = 1'b0;  opSz = 2'b10;
      addrIn = 32'd0;  dataIn = 32'd0;  sel = 1'b0;  lastOut1 = 32'd0;
      repeat (2) @(negedge clk);
      checkOutput("rst.out",  out1, 32'd0);
      checkOutput("rst.done", {31'd0, done1}, 32'd0);
      checkOutput("rst.opf",  {31'd0, opf1}, 32'd0);
      checkOutput("rst.af",   {31'd0, af1}, 32'd0);
      checkOutput("rst.afn",  {31'd0, afn1}, 32'd1);
      checkOutput("rst.afnFast", {31'd0, afn0}, 32'd1);
      reset_n = 1'b1;
      @(negedge clk);

      $display("[TB] word, byte and half-word traffic");
      applyStimulus(0, 1, 0, 2'b10, 32'h2000_0010, 32'hDEAD_BEEF, "stw", 0);
      applyStimulus(0, 0, 0, 2'b10, 32'h2000_0010, 32'h0, "ldw", 0);
      applyStimulus(0, 1, 0, 2'b00, 32'h2000_0012, 32'h0000_00A5, "stb", 0);
      applyStimulus(0, 0, 0, 2'b10, 32'h2000_0010, 32'h0, "ldw.merged", 0);
      applyStimulus(0, 0, 0, 2'b00, 32'h2000_0012, 32'h0, "ldb.s", 0);
      applyStimulus(0, 0, 1, 2'b00, 32'h2000_0012, 32'h0, "ldb.u", 0);
      applyStimulus(0, 1, 0, 2'b10, 32'h2000_0014, 32'h1122_3344, "stw14", 0);
      applyStimulus(0, 1, 0, 2'b01, 32'h2000_0016, 32'hFFFF_C3D2, "sth", 0);
      applyStimulus(0, 0, 0, 2'b01, 32'h2000_0016, 32'h0, "ldh.s", 0);
      applyStimulus(0, 0, 1, 2'b01, 32'h2000_0014, 32'h0, "ldh.u", 0);
      applyStimulus(0, 0, 0, 2'b10, 32'h2000_0014, 32'h0, "ldw14", 0);

      $display("[TB] faults and window edges");
      applyStimulus(0, 0, 0, 2'b01, 32'h2000_0011, 32'h0, "ldh.mis", 0);
      applyStimulus(0, 1, 0, 2'b10, 32'h2000_0012, 32'h5555_5555, "stw.mis", 0);
      applyStimulus(0, 0, 0, 2'b10, 32'h2000_0010, 32'h0, "ldw.keep", 0);
      applyStimulus(0, 0, 0, 2'b10, 32'h1FFF_FFFC, 32'h0, "ld.below", 0);
      applyStimulus(0, 0, 0, 2'b10, 32'h2000_1000, 32'h0, "ld.above", 0);
      applyStimulus(0, 1, 0, 2'b10, 32'h2000_0FFC, 32'h0BAD_F00D, "stw.top", 0);
      applyStimulus(0, 0, 0, 2'b10, 32'h2000_0FFC, 32'h0, "ldw.top", 0);
      applyStimulus(0, 0, 0, 2'b11, 32'h3000_0000, 32'h0, "op11", 0);
      applyStimulus(0, 0, 0, 2'b10, 32'h2000_0010, 32'h0, "ldw.pre", 0);

      $display("[TB] abort in WAIT");
      sel = 1'b0;  isWr = 1'b1;  opSz = 2'b10;
      addrIn = 32'h2000_0010;  dataIn = 32'h1234_5678;
      enN1 = 1'b0;
      @(negedge clk);
      enN1 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("abort.done", {31'd0, done1}, 32'd0);
      end
      checkOutput("abort.out", out1, lastOut1);
      applyStimulus(0, 0, 0, 2'b10, 32'h2000_0010, 32'h0, "ldw.afterAbort", 0);

      $display("[TB] reset in WAIT");
      isWr = 1'b1;  opSz = 2'b10;  isUns = 1'b0;
      addrIn = 32'h2000_0010;  dataIn = 32'h1234_5678;
      enN1 = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("rstMid.out",  out1, 32'd0);
      checkOutput("rstMid.done", {31'd0, done1}, 32'd0);
      checkOutput("rstMid.opf",  {31'd0, opf1}, 32'd0);
      checkOutput("rstMid.af",   {31'd0, af1}, 32'd0);
      checkOutput("rstMid.afn",  {31'd0, afn1}, 32'd1);
      @(negedge clk);
      enN1 = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      applyStimulus(0, 0, 0, 2'b10, 32'h2000_0010, 32'h0, "ldw.afterReset", 0);

      $display("[TB] zero wait states, held response");
      applyStimulus(1, 1, 0, 2'b10, 32'h2000_0020, 32'hCAFE_F00D, "f.stw", 0);
      applyStimulus(1, 0, 0, 2'b10, 32'h2000_0020, 32'h0, "f.ldw.hold", 5);
      applyStimulus(1, 0, 1, 2'b00, 32'h2000_0021, 32'h0, "f.ldb.u", 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
